// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, 2-entry fetch buffer, IDLE/RUN/HALT control.
// Optional delivered-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [5:0]  pc_addr,
    input  logic [31:0] imem_data,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [5:0]  ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [5:0]  redirect_pc,
    output logic        halted,
    output logic [15:0] perf_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_word_q, head_word_d;
    logic [5:0]  head_pc_q, head_pc_d;
    logic [31:0] tail_word_q, tail_word_d;
    logic [5:0]  tail_pc_q, tail_pc_d;

    logic do_pop;
    logic fetch_slot;
    logic is_marker;
    logic do_fetch;

    assign ins_valid = (count_q != 2'd0);
    assign pc_addr   = pc_q;
    assign halted    = (state_q == StHalt);

    // Empty buffer reads as zero so stale words never leak after reset or redirect.
    assign ins_data = ins_valid ? head_word_q : 32'd0;
    assign ins_pc   = ins_valid ? head_pc_q   : 6'd0;

    // Redirect overrides both the handshake and the fetch slot.
    assign do_pop     = ins_valid && ins_ready && !redirect;
    assign fetch_slot = (state_q == StRun) && en && !redirect &&
                        ((count_q != 2'd2) || do_pop);
    assign is_marker  = (imem_data == 32'd0);
    assign do_fetch   = fetch_slot && !is_marker;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        head_word_d = head_word_q;
        head_pc_d   = head_pc_q;
        tail_word_d = tail_word_q;
        tail_pc_d   = tail_pc_q;

        if (redirect) begin
            count_d = 2'd0;
            pc_d    = redirect_pc;
            state_d = en ? StRun : StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (en) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (fetch_slot && is_marker) begin
                        state_d = StHalt;
                    end else if (!en) begin
                        state_d = StIdle;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (do_fetch) begin
                pc_d = pc_q + 6'd1;
            end

            case ({do_fetch, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_word_d = imem_data;
                        head_pc_d   = pc_q;
                    end else begin
                        tail_word_d = imem_data;
                        tail_pc_d   = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_word_d = tail_word_q;
                    head_pc_d   = tail_pc_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; new word goes behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_word_d = imem_data;
                        head_pc_d   = pc_q;
                    end else begin
                        head_word_d = tail_word_q;
                        head_pc_d   = tail_pc_q;
                        tail_word_d = imem_data;
                        tail_pc_d   = pc_q;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= 6'd0;
            count_q     <= 2'd0;
            head_word_q <= 32'd0;
            head_pc_q   <= 6'd0;
            tail_word_q <= 32'd0;
            tail_pc_q   <= 6'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_word_q <= head_word_d;
            head_pc_q   <= head_pc_d;
            tail_word_q <= tail_word_d;
            tail_pc_q   <= tail_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (do_pop && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; perf_cnt expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [5:0]  pc_addr;
    logic [31:0] imem_data;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [5:0]  ins_pc;
    logic        ins_ready;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic        halted;
    logic [15:0] perf_cnt;

    logic [31:0] mem [64];
    int n_checks;
    int n_pass;

    assign imem_data = mem[pc_addr];

    fetch_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pc_addr    (pc_addr),
        .imem_data  (imem_data),
        .ins_valid  (ins_valid),
        .ins_data   (ins_data),
        .ins_pc     (ins_pc),
        .ins_ready  (ins_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted),
        .perf_cnt   (perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf_exp(input int n);
`ifdef FETCH_PERF_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        en          = 1'b0;
        ins_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 6'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[3] = 32'd0;

        // Reset state
        step();
        check("rst_valid", {31'd0, ins_valid}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_pc", {26'd0, pc_addr}, 0);
        check("rst_data", ins_data, 0);
        check("rst_inspc", {26'd0, ins_pc}, 0);
        check("rst_perf", {16'd0, perf_cnt}, 0);

        // Run to the end-of-program marker at word 3
        reset = 1'b0; en = 1'b1; ins_ready = 1'b1;
        step();
        check("idle2run_valid", {31'd0, ins_valid}, 0);
        step();
        check("seq_pc0", {26'd0, ins_pc}, 0);
        check("seq_data0", ins_data, 32'hA000_0000);
        step();
        check("seq_pc1", {26'd0, ins_pc}, 1);
        step();
        check("seq_pc2", {26'd0, ins_pc}, 2);
        check("seq_perf2", {16'd0, perf_cnt}, perf_exp(2));
        step();
        check("halt_valid", {31'd0, ins_valid}, 0);
        check("halt_flag", {31'd0, halted}, 1);
        check("halt_pc", {26'd0, pc_addr}, 3);
        check("halt_perf3", {16'd0, perf_cnt}, perf_exp(3));
        step();
        check("halt_pc_hold", {26'd0, pc_addr}, 3);
        check("halt_hold", {31'd0, halted}, 1);

        // Redirect out of HALT
        redirect = 1'b1; redirect_pc = 6'd10;
        step();
        redirect = 1'b0;
        check("rdh_halted", {31'd0, halted}, 0);
        check("rdh_pc", {26'd0, pc_addr}, 10);
        step();
        check("rdh_inspc", {26'd0, ins_pc}, 10);
        check("rdh_perf", {16'd0, perf_cnt}, perf_exp(3));

        // Asynchronous reset mid-run
        reset = 1'b1;
        #1;
        check("arst_perf", {16'd0, perf_cnt}, 0);
        check("arst_valid", {31'd0, ins_valid}, 0);
        check("arst_pc", {26'd0, pc_addr}, 0);

        // Back-pressure: buffer fills to 2 and holds
        mem[3] = 32'hA000_0003;
        ins_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
        check("bp_pc0", {26'd0, ins_pc}, 0);
        step();
        check("bp_full_pc", {26'd0, pc_addr}, 2);
        step();
        step();
        check("bp_hold_pc", {26'd0, pc_addr}, 2);
        check("bp_hold_inspc", {26'd0, ins_pc}, 0);
        check("bp_hold_data", ins_data, 32'hA000_0000);
        ins_ready = 1'b1;
        step();
        check("bp_drain1", {26'd0, ins_pc}, 1);
        step();
        check("bp_drain2", {26'd0, ins_pc}, 2);
        check("bp_drain2_data", ins_data, 32'hA000_0002);
        step();
        check("bp_drain3", {26'd0, ins_pc}, 3);
        check("bp_perf", {16'd0, perf_cnt}, perf_exp(3));

        // PC wrap from 63 to 0
        redirect = 1'b1; redirect_pc = 6'd62;
        step();
        redirect = 1'b0;
        check("wr_pc", {26'd0, pc_addr}, 62);
        check("wr_valid", {31'd0, ins_valid}, 0);
        step();
        check("wr_inspc62", {26'd0, ins_pc}, 62);
        step();
        check("wr_inspc63", {26'd0, ins_pc}, 63);
        check("wr_pcaddr0", {26'd0, pc_addr}, 0);
        step();
        check("wr_inspc0", {26'd0, ins_pc}, 0);

        // Redirect flushes a full buffer holding PCs 4,5
        redirect = 1'b1; redirect_pc = 6'd4; ins_ready = 1'b0;
        step();
        redirect = 1'b0;
        step();
        step();
        check("fl_head4", {26'd0, ins_pc}, 4);
        check("fl_pcaddr6", {26'd0, pc_addr}, 6);
        check("fl_perf_before", {16'd0, perf_cnt}, perf_exp(5));
        redirect = 1'b1; redirect_pc = 6'd40; ins_ready = 1'b1;
        step();
        redirect = 1'b0;
        check("fl_valid", {31'd0, ins_valid}, 0);
        check("fl_data_zero", ins_data, 0);
        check("fl_pc40", {26'd0, pc_addr}, 40);
        check("fl_perf_after", {16'd0, perf_cnt}, perf_exp(5));
        step();
        check("fl_inspc40", {26'd0, ins_pc}, 40);

        // en low: RUN->IDLE keeps buffer and PC
        en = 1'b0; ins_ready = 1'b0;
        step();
        step();
        check("idle_pc", {26'd0, pc_addr}, 41);
        check("idle_inspc", {26'd0, ins_pc}, 40);
        check("idle_valid", {31'd0, ins_valid}, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
